// File: rtl/ctrl_cdc_tx_if.sv
// rtl/ctrl_cdc_tx_if.sv - valid/ready word bus feeding the toggle CDC sender
interface ctrl_cdc_tx_if #(
  parameter int DATA_W = 4
) ();
  logic [DATA_W-1:0] ctrl_in;
  logic              ctrl_valid;
  logic              ctrl_ready;

  modport master (output ctrl_in, output ctrl_valid, input ctrl_ready);
  modport slave  (input ctrl_in, input ctrl_valid, output ctrl_ready);
endinterface

// File: rtl/ctrl_cdc_tx.sv
// rtl/ctrl_cdc_tx.sv - source-domain toggle req/ack sender for control words
module ctrl_cdc_tx #(
  parameter int DATA_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clkA,
  input  logic              rstA,
  ctrl_cdc_tx_if.slave      ctrl,
  output logic [DATA_W-1:0] ctrl_hold,
  output logic              req_tgl,
  input  logic              ack_tgl_async,
  output logic              timeout,
  output logic [7:0]        xfer_cnt
);

  // Counter just wide enough to hold TIMEOUT_CYC; one bit when the timeout is off.
  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] sync;
  logic                   ack_sync;
  logic                   ack_match;
  logic                   ready;
  logic                   accept;
  logic                   done;
  logic [CNT_W-1:0]       to_cnt;

  assign ack_sync   = sync[SYNC_STAGES-1];
  assign ack_match  = (ack_sync == req_tgl);
  assign ctrl.ctrl_ready = ready;

  // Ack synchronizer: the only consumer of the asynchronous ack toggle.
  always_ff @(posedge clkA or negedge rstA) begin
    if (!rstA) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ack_tgl_async};
    end
  end

  // FSM state register.
  always_ff @(posedge clkA or negedge rstA) begin
    if (!rstA) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake decode; a stale ack in IDLE keeps ready low.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    accept     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = ack_match;
        if (ctrl.ctrl_valid && ack_match) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (ack_match) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Word capture, request toggle and completed-transfer count.
  always_ff @(posedge clkA or negedge rstA) begin
    if (!rstA) begin
      ctrl_hold <= '0;
      req_tgl   <= 1'b0;
      xfer_cnt  <= 8'd0;
    end else begin
      if (accept) begin
        ctrl_hold <= ctrl.ctrl_in;
        req_tgl   <= ~req_tgl;
      end
      if (done) begin
        xfer_cnt <= xfer_cnt + 8'd1;
      end
    end
  end

  // Overdue-ack watchdog: saturating count, single pulse on reaching the limit,
  // and a completing ack on the same cycle suppresses the pulse.
  always_ff @(posedge clkA or negedge rstA) begin
    if (!rstA) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (accept) begin
        to_cnt <= '0;
      end else if ((TIMEOUT_CYC != 0) && (state == WAIT) && !done && (to_cnt != TO_MAX)) begin
        to_cnt <= to_cnt + 1'b1;
        if (to_cnt == TO_LAST) begin
          timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/ctrl_cdc_tx.md
# ctrl_cdc_tx

Source-domain sender for a toggle-based request/acknowledge crossing that moves 4-bit control words into another clock domain. It accepts a word on a valid/ready interface and holds it stable on `ctrl_hold`. It flips `req_tgl` to announce the word, then waits for the destination's echoed `ack_tgl_async`, which it synchronizes internally. It sits in the clkA domain, in front of the destination-side synchronizer/receiver, and provides the flow control and stable-data guarantee that a bare flop synchronizer lacks.

## Interface
- `DATA_W`, default 4: control word width.
- `SYNC_STAGES`, default 2: flops in the ack synchronizer; minimum 2.
- `TIMEOUT_CYC`, default 255: cycles in WAIT before `timeout` fires; 0 disables the timeout.
- `clkA` in 1: the single clock.
- `rstA` in 1: reset, asynchronous, active-low.
- `ctrl_in` in DATA_W: word to send.
- `ctrl_valid` in 1: `ctrl_in` valid.
- `ctrl_ready` out 1: block can accept a word.
- `ctrl_hold` out DATA_W: registered word, stable from the req toggle until ack.
- `req_tgl` out 1: registered request toggle, crossing to the destination domain.
- `ack_tgl_async` in 1: destination's ack toggle, asynchronous to clkA.
- `timeout` out 1: one-cycle pulse when an ack is overdue.
- `xfer_cnt` out 8: count of completed transfers; wraps.

## Operation
- Ack synchronizer: a chain of SYNC_STAGES flops clocked by clkA; the last stage is `ack_sync`. No other logic ever reads `ack_tgl_async` directly.
- FSM has two states, IDLE and WAIT.
- IDLE:
  - `ctrl_ready` = (`ack_sync` == `req_tgl`).
  - On `ctrl_valid` && `ctrl_ready`: `ctrl_hold` <= `ctrl_in`, `req_tgl` <= ~`req_tgl`, timeout counter <= 0, go to WAIT.
- WAIT:
  - `ctrl_ready` = 0. `ctrl_valid` and `ctrl_in` are ignored; `ctrl_hold` and `req_tgl` do not change.
  - When `ack_sync` == `req_tgl`: go to IDLE and increment `xfer_cnt` modulo 256 (255 -> 0).
  - Otherwise, when TIMEOUT_CYC != 0, the counter increments and saturates at TIMEOUT_CYC. `timeout` pulses for exactly one cycle on the cycle the counter reaches TIMEOUT_CYC, at most once per transfer.
  - The FSM stays in WAIT after a timeout; the toggle protocol cannot be aborted safely.
- Spurious ack: a mismatch seen in IDLE (`ack_sync` != `req_tgl`) holds `ctrl_ready` low until the two match again. This prevents a stale ack from completing the next transfer.
- `ctrl_ready` is combinational from state, `ack_sync` and `req_tgl` only. It never depends on `ctrl_valid`.

## Timing
- Reset values while `rstA` is low:
  - `ctrl_hold` = 0, `req_tgl` = 0, all synchronizer flops = 0.
  - FSM = IDLE, timeout counter = 0, `timeout` = 0, `xfer_cnt` = 0.
  - `ctrl_ready` = 1.
- Reset deassertion is synchronized externally.
- Accept: handshake at edge E -> `req_tgl` and `ctrl_hold` updated after E; `ctrl_ready` = 0 from E until the ack completes.
- Ack latency with SYNC_STAGES = 2:
  - `ack_tgl_async` toggles and is first captured at edge N.
  - `ack_sync` updates after N+1.
  - FSM is in IDLE and `ctrl_ready` is high after N+2.
  - General case: SYNC_STAGES + 1 edges.
- Throughput: at most one word per (destination round trip + SYNC_STAGES + 1) clkA cycles. No back-to-back accepts.
- Simultaneous events: if the ack completes on the same cycle the counter would reach TIMEOUT_CYC, the ack wins and `timeout` stays 0.
- Reset mid-transfer: all state returns to reset values immediately. The destination side must be reset at the same time; otherwise the spurious-ack rule holds `ctrl_ready` low.

## Test plan
- Reset: assert `rstA` during a WAIT -> `ctrl_ready` = 1, `req_tgl` = 0, `ctrl_hold` = 0, `xfer_cnt` = 0 on the next sample.
- Single transfer: `ctrl_in` = 4'hA with valid -> `ctrl_hold` = 4'hA, `req_tgl` = 1. Echo ack after 5 cycles -> `ctrl_ready` returns exactly 3 edges after the ack is captured; `xfer_cnt` = 1.
- Hold stability: during WAIT, drive valid with 4'h5 -> `ctrl_hold` stays 4'hA and `req_tgl` stays constant until ack.
- Timeout: TIMEOUT_CYC = 8, never ack -> `timeout` high for exactly 1 cycle, 8 cycles after entering WAIT. State stays WAIT; a late ack then completes normally.
- Spurious ack: toggle `ack_tgl_async` while in IDLE -> `ctrl_ready` = 0 after 2 edges, no transfer accepted; toggle back -> `ctrl_ready` = 1.
- Wrap: run 257 transfers with a random 0-20 cycle ack delay -> `xfer_cnt` = 1. Each `ctrl_hold` matches its accepted word, and the scoreboard shows no drops or duplicates.
